// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//   Sequences branch resolution in the ID stage and turns a resolved-taken
//   branch into a PC redirect request for the fetch stage. The redirect is
//   only raised once the delay-slot instruction has been fetched, and it is
//   held until the PC register accepts it. The module also tracks whether
//   the next instruction leaving ID is a delay slot, for exception handling.
//
// Optional feature (macro BRANCH_PERF_CNT_EN): adds the CNT_W parameter and
//   taken / not-taken / stall performance counters. The counters wrap, and
//   flush_i does not clear them.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   id_valid_i           ID holds a valid instruction
//   id_is_branch_i       ID instruction is a branch or jump
//   opnd_ready_i         branch operands are final
//   do_branch_i          taken decision from the branch condition unit
//   target_i             branch/jump target address
//   id_advance_i         ID instruction moves to EX this cycle
//   ds_fetched_i         delay-slot instruction is in IF/ID or later
//   redirect_ready_i     PC register accepts the redirect this cycle
//   flush_i              exception/ERET pipeline flush
//   redirect_valid_o     redirect request (registered)
//   redirect_pc_o        redirect address, 0 when no request (registered)
//   id_stall_o           stall the ID stage (combinational)
//   next_in_ds_o         next instruction leaving ID is a delay slot
//   branch_resolved_o    one-cycle pulse after a branch resolves
//   taken_cnt_o, not_taken_cnt_o, stall_cnt_o   (BRANCH_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module branch_redirect_ctrl #(
  parameter int unsigned ADDR_W = 32
`ifdef BRANCH_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid_i,
  input  logic              id_is_branch_i,
  input  logic              opnd_ready_i,
  input  logic              do_branch_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              id_advance_i,
  input  logic              ds_fetched_i,
  input  logic              redirect_ready_i,
  input  logic              flush_i,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              id_stall_o,
  output logic              next_in_ds_o,
  output logic              branch_resolved_o
`ifdef BRANCH_PERF_CNT_EN
  , output logic [CNT_W-1:0] taken_cnt_o,
  output logic [CNT_W-1:0]  not_taken_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DS  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [ADDR_W-1:0] pc_d;
  logic              valid_d;
  logic              nds_d;
  logic              resolve;

  // A branch can only resolve while no earlier redirect is outstanding, so a
  // branch sitting in a delay slot waits until the handshake completes.
  always_comb begin
    resolve = (state_q == IDLE) & id_valid_i & id_is_branch_i & opnd_ready_i
              & id_advance_i & ~flush_i;
    id_stall_o = id_valid_i & id_is_branch_i
                 & (~opnd_ready_i | (state_q != IDLE));
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    case (state_q)
      IDLE: begin
        if (resolve && do_branch_i) begin
          tgt_d   = target_i;
          state_d = ds_fetched_i ? REDIRECT : WAIT_DS;
        end
      end
      WAIT_DS: begin
        if (ds_fetched_i) state_d = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d = IDLE;
      tgt_d   = '0;
    end

    // Output registers are loaded from the next state so that the request
    // appears in the first cycle of REDIRECT and drops with the handshake.
    valid_d = (state_d == REDIRECT);
    pc_d    = valid_d ? tgt_d : '0;

    // Setting wins over clearing: the resolving branch itself advances.
    nds_d = next_in_ds_o;
    if (flush_i)                         nds_d = 1'b0;
    else if (resolve)                    nds_d = 1'b1;
    else if (id_valid_i && id_advance_i) nds_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q           <= IDLE;
      tgt_q             <= '0;
      redirect_valid_o  <= 1'b0;
      redirect_pc_o     <= '0;
      next_in_ds_o      <= 1'b0;
      branch_resolved_o <= 1'b0;
    end else begin
      state_q           <= state_d;
      tgt_q             <= tgt_d;
      redirect_valid_o  <= valid_d;
      redirect_pc_o     <= pc_d;
      next_in_ds_o      <= nds_d;
      branch_resolved_o <= resolve;
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      taken_cnt_o     <= '0;
      not_taken_cnt_o <= '0;
      stall_cnt_o     <= '0;
    end else begin
      if (resolve &&  do_branch_i) taken_cnt_o     <= taken_cnt_o + 1'b1;
      if (resolve && !do_branch_i) not_taken_cnt_o <= not_taken_cnt_o + 1'b1;
      if (id_stall_o)              stall_cnt_o     <= stall_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences MIPS branch resolution in ID and turns a resolved-taken branch into a PC redirect request to the fetch stage.
- Sits beside the ID-stage branch condition unit, which supplies the combinational taken decision.
- Enforces delay-slot ordering: the redirect is issued only after the delay-slot instruction is fetched. Holds the redirect until the PC register accepts it, and tracks the delay-slot flag for exception handling.

Parameters:
- ADDR_W, 32, PC/target address width.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- id_valid_i  input  1  ID holds a valid instruction
- id_is_branch_i  input  1  ID instruction is a branch or jump
- opnd_ready_i  input  1  branch operands are final (no pending load-use)
- do_branch_i  input  1  taken decision from the branch condition unit
- target_i  input  ADDR_W  branch/jump target address
- id_advance_i  input  1  ID instruction moves to EX this cycle
- ds_fetched_i  input  1  delay-slot instruction is held in IF/ID or later
- redirect_ready_i  input  1  PC register accepts the redirect this cycle
- flush_i  input  1  exception/ERET pipeline flush
- redirect_valid_o  output  1  redirect request
- redirect_pc_o  output  ADDR_W  redirect address
- id_stall_o  output  1  stall the ID stage
- next_in_ds_o  output  1  the next instruction leaving ID is a delay slot
- branch_resolved_o  output  1  one-cycle pulse when a branch resolves

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous, active-low.
- Reset values: state=IDLE, redirect_valid_o=0, redirect_pc_o=0, next_in_ds_o=0, branch_resolved_o=0, latched target=0.
- States: IDLE, WAIT_DS, REDIRECT.
- Resolve event (R): state==IDLE & id_valid_i & id_is_branch_i & opnd_ready_i & id_advance_i & !flush_i.
- id_stall_o is combinational. It is 1 when id_valid_i & id_is_branch_i & (!opnd_ready_i | state!=IDLE). A branch in the delay slot therefore waits until the previous redirect completes.
- IDLE transitions on R:
  - do_branch_i=0: stay in IDLE.
  - do_branch_i=1 & ds_fetched_i=1: latch target_i, go to REDIRECT.
  - do_branch_i=1 & ds_fetched_i=0: latch target_i, go to WAIT_DS.
- WAIT_DS: on ds_fetched_i=1, go to REDIRECT next cycle.
- REDIRECT:
  - redirect_valid_o=1 and redirect_pc_o=latched target. Both are registered outputs.
  - Latency: R in cycle T with ds_fetched_i=1 gives redirect_valid_o=1 in T+1.
  - Valid and pc stay stable until redirect_ready_i=1. The handshake completes in that cycle, and the next state is IDLE with redirect_valid_o=0.
- branch_resolved_o: registered, equals 1 in the cycle after R, regardless of taken/not-taken.
- next_in_ds_o:
  - Set in the cycle after R.
  - Cleared in the cycle after the next id_valid_i & id_advance_i.
  - Set has priority if both occur in one cycle.
- flush_i priority:
  - Overrides everything. The next state is IDLE; redirect_valid_o, next_in_ds_o and branch_resolved_o go to 0 next cycle; the latched target is cleared.
  - flush_i in the same cycle as redirect_ready_i also yields IDLE.
- Asynchronous reset mid-REDIRECT: the request is dropped immediately and no handshake completes.
- redirect_pc_o is 0 whenever redirect_valid_o=0.

Optional Feature:
- Macro: BRANCH_PERF_CNT_EN.
- When defined, three CNT_W-bit counters are added: taken_cnt_o, not_taken_cnt_o (incremented on R by do_branch_i) and stall_cnt_o (incremented each cycle id_stall_o=1).
  - Counters reset to 0 and wrap modulo 2^CNT_W.
  - flush_i does not clear them.
- When undefined, these ports and registers do not exist and the remaining behaviour is identical.

Test Plan:
- Not-taken branch: id_valid_i=id_is_branch_i=opnd_ready_i=id_advance_i=1, do_branch_i=0 at T -> branch_resolved_o=1 at T+1, redirect_valid_o stays 0, next_in_ds_o=1 at T+1.
- Taken, delay slot fetched: do_branch_i=1, target_i=0xBFC00380, ds_fetched_i=1 at T, redirect_ready_i=1 at T+1 -> redirect_valid_o=1 and redirect_pc_o=0xBFC00380 at T+1 only, IDLE at T+2.
- Taken, delay slot late, PC busy: ds_fetched_i=0 at T, rising at T+3; redirect_ready_i=0 until T+6 -> redirect_valid_o=1 from T+4 to T+6 with pc stable, 0 at T+7.
- Operand hazard: opnd_ready_i=0 for 2 cycles with a branch in ID -> id_stall_o=1 for 2 cycles; resolve on the 3rd cycle. With BRANCH_PERF_CNT_EN: stall_cnt_o=2, taken_cnt_o=1.
- Branch in delay slot while in REDIRECT -> id_stall_o=1 until the handshake completes, then it resolves normally.
- flush_i=1 in WAIT_DS or REDIRECT -> next cycle redirect_valid_o=0, next_in_ds_o=0, state IDLE. resetn low mid-REDIRECT -> outputs 0 immediately.
